// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program sequencer between instruction memory and exe_engine
// Optional EXEC watchdog is built only when SEQ_WATCHDOG_EN is defined.
module instr_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int INSTR_W     = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [4:0]         instr,
  output logic               issue_valid,
  input  logic               unit_done,
  output logic               busy,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc,
  output logic               wdog_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_EXEC, S_HALT
  } state_t;

  localparam logic [2:0] OP_STOP    = 3'b111;
  localparam logic [2:0] OP_NOP     = 3'b101;
  localparam logic [4:0] INSTR_IDLE = 5'b10100;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [4:0]        r_instr;
  logic              w_pc_inc;
  logic              w_pc_clr;
  logic              w_wdog_trip;
  logic              w_unused_rsvd;

  // Reserved upper instruction bits are deliberately ignored.
  assign w_unused_rsvd = ^imem_rdata;

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] r_wdog_cnt;
  logic            r_wdog_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wdog_cnt <= '0;
    end else if (r_state == S_EXEC && !unit_done) begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end
  end

  // Trips on the last allowed EXEC cycle; a unit_done arriving in that cycle still wins.
  assign w_wdog_trip = (r_state == S_EXEC) && !unit_done &&
                       (r_wdog_cnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog_err <= 1'b0;
    end else if (w_pc_clr) begin
      r_wdog_err <= 1'b0;
    end else if (w_wdog_trip) begin
      r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_wdog_trip = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_pc_inc = 1'b0;
    w_pc_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next   = S_FETCH;
          w_pc_clr = 1'b1;
        end
      end
      S_HALT: begin
        if (start) begin
          w_next   = S_FETCH;
          w_pc_clr = 1'b1;
        end
      end
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (imem_rdata[4:2])
          OP_STOP: w_next = S_HALT;
          OP_NOP: begin
            w_next   = S_FETCH;
            w_pc_inc = 1'b1;
          end
          default: w_next = S_ISSUE;
        endcase
      end
      S_ISSUE: w_next = S_EXEC;
      S_EXEC: begin
        if (unit_done) begin
          w_next   = S_FETCH;
          w_pc_inc = 1'b1;
        end else if (w_wdog_trip) begin
          w_next = S_HALT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // pc wraps silently at the top of the address space.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
    end else if (w_pc_clr) begin
      r_pc <= '0;
    end else if (w_pc_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= INSTR_IDLE;
    end else if (r_state == S_DECODE) begin
      r_instr <= imem_rdata[4:0];
    end
  end

  assign imem_rd_en  = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign issue_valid = (r_state == S_ISSUE);
  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed bench with issue scoreboard for instr_sequencer
// Watchdog steps run only when SEQ_WATCHDOG_EN is defined.
module tb_instr_sequencer;

  localparam int ADDR_W  = 2;
  localparam int INSTR_W = 8;
  localparam int WDOG    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               unit_done;
  logic               imem_rd_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [4:0]         instr;
  logic               issue_valid;
  logic               busy;
  logic               halted;
  logic [ADDR_W-1:0]  pc;
  logic               wdog_err;

  logic [INSTR_W-1:0] mem [4];
  logic [4:0]         exp_q [$];
  int                 pc_trace [$];
  int                 n_issue = 0;
  int                 errors = 0;
  int                 checks = 0;
  int                 resp_delay = 2;
  bit                 resp_en = 1'b1;
  int                 manual_req = 0;

  instr_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .issue_valid(issue_valid), .unit_done(unit_done),
    .busy(busy), .halted(halted), .pc(pc), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every issue pulse pops the next expected instr; fetches log pc.
  always @(negedge clk) begin
    if (!reset) begin
      if (issue_valid) begin
        n_issue++;
        if (exp_q.size() == 0) chk("issue_unexpected", {31'd0, issue_valid}, 32'd0);
        else chk("issue_instr", {27'd0, instr}, {27'd0, exp_q.pop_front()});
      end
      if (imem_rd_en) pc_trace.push_back(int'(pc));
    end
  end

  // Execution-unit model: auto-completion resp_delay cycles after issue, or manual pulses.
  initial begin
    int cnt;
    int seen;
    cnt = 0;
    seen = 0;
    unit_done = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        cnt = 0;
        unit_done = 1'b0;
        seen = manual_req;
      end else begin
        unit_done = (cnt == 1) || (manual_req != seen);
        seen = manual_req;
        if (cnt > 0) cnt--;
        if (issue_valid && resp_en) cnt = resp_delay;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic chk_trace(input string tag, input int len,
                           input int e0, input int e1, input int e2, input int e3, input int e4);
    int e [5];
    e = '{e0, e1, e2, e3, e4};
    chk({tag, "_len"}, pc_trace.size(), len);
    for (int i = 0; i < len && i < pc_trace.size(); i++) chk(tag, pc_trace[i], e[i]);
  endtask

  initial begin
    int base;
    int n;
    bit busy_drop;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h1C;
    tick(2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_issue", {31'd0, issue_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
    chk("rst_pc", {30'd0, pc}, 32'd0);
    chk("rst_instr", {27'd0, instr}, 32'h14);
    chk("rst_wdog", {31'd0, wdog_err}, 32'd0);
    reset = 1'b0;
    tick(1);

    // add, sub rd_mem, stop with 2-cycle unit latency
    mem[0] = 8'h00; mem[1] = 8'h06; mem[2] = 8'h1C;
    resp_delay = 2;
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00110);
    pc_trace.delete();
    base = n_issue;
    pulse_start();
    chk("lat_fetch_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("lat_fetch_busy", {31'd0, busy}, 32'd1);
    tick(1);
    chk("lat_decode_issue", {31'd0, issue_valid}, 32'd0);
    tick(1);
    chk("lat_issue", {31'd0, issue_valid}, 32'd1);
    wait_halt("p1_halt", 60);
    chk("p1_pc", {30'd0, pc}, 32'd2);
    chk("p1_issues", n_issue - base, 32'd2);
    chk("p1_instr_stop", {27'd0, instr}, 32'h1C);
    chk_trace("p1_trace", 3, 0, 1, 2, 0, 0);

    // unused opcode acts as NOP; restart from HALT
    mem[0] = 8'h14; mem[1] = 8'h08; mem[2] = 8'h1C;
    exp_q.push_back(5'b01000);
    pc_trace.delete();
    base = n_issue;
    pulse_start();
    chk("p2_restart_pc", {30'd0, pc}, 32'd0);
    wait_halt("p2_halt", 60);
    chk("p2_pc", {30'd0, pc}, 32'd2);
    chk("p2_issues", n_issue - base, 32'd1);
    chk_trace("p2_trace", 3, 0, 1, 2, 0, 0);

    // no STOP: pc wraps, busy never drops; then reset mid-EXEC
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    resp_delay = 1;
    repeat (6) exp_q.push_back(5'b00000);
    pc_trace.delete();
    busy_drop = 1'b0;
    n = 0;
    pulse_start();
    while (pc_trace.size() < 5 && n < 100) begin
      if (!busy) busy_drop = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("wrap_busy_drop", {31'd0, busy_drop}, 32'd0);
    chk_trace("wrap_trace", 5, 0, 1, 2, 3, 0);
    n = 0;
    while (!issue_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_reissue", {31'd0, issue_valid}, 32'd1);
    tick(1);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_exec_busy", {31'd0, busy}, 32'd0);
    chk("rst_exec_pc", {30'd0, pc}, 32'd0);
    chk("rst_exec_issue", {31'd0, issue_valid}, 32'd0);
    chk("rst_exec_instr", {27'd0, instr}, 32'h14);
    tick(1);
    reset = 1'b0;
    exp_q.delete();
    tick(1);

    // stray unit_done in FETCH and start in EXEC are ignored
    mem[0] = 8'h00; mem[1] = 8'h1C; mem[2] = 8'h1C; mem[3] = 8'h1C;
    resp_en = 1'b0;
    exp_q.push_back(5'b00000);
    pc_trace.delete();
    base = n_issue;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    manual_req++;
    chk("stray_fetch", {31'd0, imem_rd_en}, 32'd1);
    tick(2);
    chk("stray_issue", {31'd0, issue_valid}, 32'd1);
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("stray_pc_a", {30'd0, pc}, 32'd0);
    tick(1);
    chk("stray_pc_b", {30'd0, pc}, 32'd0);
    chk("stray_busy", {31'd0, busy}, 32'd1);
    chk("stray_no_refetch", {31'd0, imem_rd_en}, 32'd0);
    manual_req++;
    wait_halt("stray_halt", 30);
    chk("stray_final_pc", {30'd0, pc}, 32'd1);
    chk("stray_issues", n_issue - base, 32'd1);
    chk_trace("stray_trace", 2, 0, 1, 0, 0, 0);

`ifdef SEQ_WATCHDOG_EN
    mem[0] = 8'h00;
    exp_q.push_back(5'b00000);
    pulse_start();
    n = 0;
    while (!issue_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wd_issue", {31'd0, issue_valid}, 32'd1);
    tick(4);
    chk("wd_exec4_busy", {31'd0, busy}, 32'd1);
    tick(1);
    chk("wd_halted", {31'd0, halted}, 32'd1);
    chk("wd_err", {31'd0, wdog_err}, 32'd1);
    chk("wd_pc", {30'd0, pc}, 32'd0);
    mem[0] = 8'h1C;
    resp_en = 1'b1;
    pulse_start();
    chk("wd_err_clr", {31'd0, wdog_err}, 32'd0);
    chk("wd_restart_pc", {30'd0, pc}, 32'd0);
    wait_halt("wd_restart_halt", 20);
`else
    chk("wdog_tied", {31'd0, wdog_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
